// File: rtl/rib_wb_pkg.sv
// Shared types and constants for the RIB-to-Wishbone data-port bridge.
//   rib_wb_state_e   : bridge FSM state encoding (idle, bus cycle open, one-cycle completion)
//   ERR_DATA_DEFAULT : read data returned to the core when a bus cycle is forcibly terminated
package rib_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } rib_wb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rib_wb_watchdog.sv
// Bus-cycle watchdog for rib_wb_bridge (only instantiated when RIB_WB_TIMEOUT_EN is defined).
// Counts BUSY cycles that see no acknowledge and pulses expire_o in the BUSY cycle in which
// the TIMEOUT_CYCLES-th unacknowledged cycle is reached.
//   clk      : core clock
//   rst      : asynchronous active-high reset
//   start_i  : bridge is entering BUSY on the next edge (clears the count)
//   busy_i   : bridge is in BUSY this cycle
//   ack_i    : Wishbone acknowledge
//   expire_o : combinational expiry pulse; never asserted together with ack_i
module rib_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Count value held during the last permitted BUSY cycle.
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = busy_i && !ack_i && (cnt_q == LastCnt);
    cnt_d    = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rib_wb_bridge.sv
// RIB data port to Wishbone classic bridge.
// Each single-cycle RIB request becomes one registered Wishbone cycle; the core is stalled via
// rib_hold_o until ack, and read data is presented for one DONE cycle (and held afterwards).
// Optional macro RIB_WB_TIMEOUT_EN adds a watchdog that terminates a BUSY cycle after
// TIMEOUT_CYCLES unacknowledged cycles, returns ERR_DATA on reads and sets the sticky err_o.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   rib_req_i/we_i/addr_i/data_i : core request (address, write enable, write data)
//   rib_data_o                : registered read data to core
//   rib_hold_o                : stall core pipeline
//   wb_cyc_o/stb_o/we_o/addr_o/data_o : registered Wishbone master outputs
//   wb_data_i, wb_ack_i       : Wishbone read data and acknowledge
//   err_o                     : sticky bus-error flag (cleared only by rst)
module rib_wb_bridge
  import rib_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH                = 32,
  parameter int unsigned DATA_WIDTH                = 32,
  parameter int unsigned TIMEOUT_CYCLES            = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA        = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rib_req_i,
  input  logic                  rib_we_i,
  input  logic [ADDR_WIDTH-1:0] rib_addr_i,
  input  logic [DATA_WIDTH-1:0] rib_data_i,
  output logic [DATA_WIDTH-1:0] rib_data_o,
  output logic                  rib_hold_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  output logic                  err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rib_wb_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  rib_wb_state_e state_q, state_d;

  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic start;
  logic expire;

  assign start = (state_q == StIdle) && rib_req_i;

`ifdef RIB_WB_TIMEOUT_EN
  rib_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .busy_i   (state_q == StBusy),
    .ack_i    (wb_ack_i),
    .expire_o (expire)
  );
`else
  // No watchdog: BUSY waits for ack indefinitely and err_q can never be set.
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (rib_req_i) begin
          state_d = StBusy;
          cyc_d   = 1'b1;
          we_d    = rib_we_i;
          addr_d  = rib_addr_i;
          wdata_d = rib_data_i;
        end
      end
      StBusy: begin
        // Ack takes priority over a simultaneous watchdog expiry.
        if (wb_ack_i) begin
          state_d = StDone;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rdata_d = wb_data_i;
        end else if (expire) begin
          state_d = StDone;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      StDone: begin
        // The core still presents the completed request here, so it is not re-issued.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Hold is combinational on the request in IDLE so the core freezes on the accepting edge.
  always_comb begin
    rib_hold_o = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:  rib_hold_o = rib_req_i;
        StBusy:  rib_hold_o = 1'b1;
        StDone:  rib_hold_o = 1'b0;
        default: rib_hold_o = 1'b0;
      endcase
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = wdata_q;
  assign rib_data_o = rdata_q;
  assign err_o      = err_q;

endmodule
